// File: rtl/cnt_ctrl_pkg.sv
// Shared types and constants for the counting-window controller.
package cnt_ctrl_pkg;

  localparam int unsigned CNT_W       = 4;
  localparam int unsigned LAPS_MAX    = 15;
  localparam int unsigned ACK_TMO_DEF = 6;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_STOP = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  // Window completion status held until the next accepted request
  typedef struct packed {
    logic [CNT_W-1:0] result;
    logic [CNT_W-1:0] laps;
    logic             err;
  } win_sts_t;

  // True when the external counter rolled over from all-ones to zero
  function automatic logic is_wrap(input logic [CNT_W-1:0] prev,
                                   input logic [CNT_W-1:0] cur);
    return (prev == '1) && (cur == '0);
  endfunction

endpackage

// File: rtl/cnt_window_ctrl_if.sv
// Request/status and counter-control signals of the window controller.
interface cnt_window_ctrl_if #(
  parameter int unsigned WIN_W = 8
);
  import cnt_ctrl_pkg::*;

  logic             req;
  logic [WIN_W-1:0] win_len;
  logic             abort;
  logic [CNT_W-1:0] count;
  logic             stop_d2;
  logic             start;
  logic             stop;
  logic             busy;
  logic             done;
  logic [CNT_W-1:0] result;
  logic [CNT_W-1:0] laps;
  logic             err;

  modport master (
    output req, win_len, abort, count, stop_d2,
    input  start, stop, busy, done, result, laps, err
  );

  modport slave (
    input  req, win_len, abort, count, stop_d2,
    output start, stop, busy, done, result, laps, err
  );

endinterface

// File: rtl/cnt_ctrl_timer.sv
// Loadable up-counter with a terminal-count compare against a target value.
module cnt_ctrl_timer #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         en,
  input  logic [W-1:0] target,
  output logic         tc_c
);

  logic [W-1:0] cnt_q;

  // Load has priority over counting
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (load) begin
      cnt_q <= load_val;
    end else if (en) begin
      cnt_q <= cnt_q + W'(1);
    end
  end

  assign tc_c = (cnt_q == target);

endmodule

// File: rtl/cnt_window_ctrl.sv
// Opens a counting window on an external 4-bit counter, closes it by length,
// abort or stop-acknowledge timeout, and reports the captured count.
module cnt_window_ctrl
  import cnt_ctrl_pkg::*;
#(
  parameter int unsigned WIN_W   = 8,
  parameter int unsigned ACK_TMO = ACK_TMO_DEF
) (
  input  logic                clk,
  input  logic                reset,
  cnt_window_ctrl_if.slave    bus
);

  localparam int unsigned TMO_W = (ACK_TMO < 2) ? 1 : $clog2(ACK_TMO + 1);

  state_e           state_q, state_d;
  logic             start_q, start_d;
  logic             stop_q, stop_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  win_sts_t         sts_q, sts_d;
  logic [WIN_W-1:0] win_len_q;
  logic [CNT_W-1:0] count_q;
  logic             armed_q;
  logic             el_load, el_tc_c;
  logic             tmo_load, tmo_tc_c;

  // Elapsed RUN cycles, compared against the latched window length
  cnt_ctrl_timer #(.W(WIN_W)) u_elapsed (
    .clk      (clk),
    .rst_n    (reset),
    .load     (el_load),
    .load_val (WIN_W'(1)),
    .en       (state_q == ST_RUN),
    .target   (win_len_q),
    .tc_c     (el_tc_c)
  );

  // Cycles spent in STOP waiting for the synchronised acknowledge
  cnt_ctrl_timer #(.W(TMO_W)) u_ack_tmo (
    .clk      (clk),
    .rst_n    (reset),
    .load     (tmo_load),
    .load_val (TMO_W'(1)),
    .en       (state_q == ST_STOP),
    .target   (TMO_W'(ACK_TMO)),
    .tc_c     (tmo_tc_c)
  );

  // Next state and next registered outputs
  always_comb begin
    state_d  = state_q;
    start_d  = start_q;
    stop_d   = stop_q;
    done_d   = 1'b0;
    sts_d    = sts_q;
    el_load  = 1'b0;
    tmo_load = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (armed_q && bus.req) begin
          sts_d = '0;
          if (bus.win_len != '0) begin
            state_d = ST_RUN;
            start_d = 1'b1;
            el_load = 1'b1;
          end else begin
            state_d = ST_DONE;
            done_d  = 1'b1;
          end
        end
      end

      ST_RUN: begin
        if (is_wrap(count_q, bus.count) && (sts_q.laps != CNT_W'(LAPS_MAX))) begin
          sts_d.laps = sts_q.laps + CNT_W'(1);
        end
        // Abort and length match collapse into the same single exit
        if (bus.abort || el_tc_c) begin
          state_d  = ST_STOP;
          start_d  = 1'b0;
          stop_d   = 1'b1;
          tmo_load = 1'b1;
        end
      end

      ST_STOP: begin
        if (bus.stop_d2 || tmo_tc_c) begin
          sts_d.result = bus.count;
          if (!bus.stop_d2) begin
            sts_d.err = 1'b1;
          end
          state_d = ST_DONE;
          stop_d  = 1'b0;
          done_d  = 1'b1;
        end
      end

      ST_DONE: begin
        state_d = ST_IDLE;
        start_d = 1'b0;
        stop_d  = 1'b0;
      end

      default: begin
        state_d = ST_IDLE;
        start_d = 1'b0;
        stop_d  = 1'b0;
      end
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  // State and output registers; armed_q enforces one IDLE edge after reset
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_IDLE;
      start_q   <= 1'b0;
      stop_q    <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      sts_q     <= '0;
      win_len_q <= '0;
      count_q   <= '0;
      armed_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      start_q <= start_d;
      stop_q  <= stop_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      sts_q   <= sts_d;
      count_q <= bus.count;
      armed_q <= 1'b1;
      if (el_load) begin
        win_len_q <= bus.win_len;
      end
    end
  end

  assign bus.start  = start_q;
  assign bus.stop   = stop_q;
  assign bus.busy   = busy_q;
  assign bus.done   = done_q;
  assign bus.result = sts_q.result;
  assign bus.laps   = sts_q.laps;
  assign bus.err    = sts_q.err;

endmodule

// File: tb/tb_cnt_window_ctrl.sv
// Self-checking bench for cnt_window_ctrl: window table with scoreboard plus
// hand-written reset and request-hold sequences.
module tb_cnt_window_ctrl;
  import cnt_ctrl_pkg::*;

  localparam int unsigned WIN_W = 8;
  localparam int unsigned NOACK = 99;
  localparam int unsigned MAX_CYC = 400;

  logic clk   = 1'b0;
  logic reset = 1'b1;

  cnt_window_ctrl_if #(.WIN_W(WIN_W)) bus ();

  cnt_window_ctrl #(.WIN_W(WIN_W), .ACK_TMO(6)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // count modes: 0 hold seed, 1 seed+k, 2 alternate 15/0 (15 on even k)
  typedef struct {
    int unsigned win_len;
    int unsigned abort_at;
    int unsigned ack_dly;
    int unsigned mode;
    int unsigned seed;
    bit          toggle_req;
    int unsigned exp_start;
    int unsigned exp_stop;
    int unsigned exp_lat;
    int unsigned exp_result;
    int unsigned exp_laps;
    bit          exp_err;
  } vec_t;

  vec_t vecs[9];
  vec_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic check(input string name, input int unsigned act, input int unsigned exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Advance one clock and sample just after the edge; start/stop exclusivity every cycle
  task automatic tick();
    @(posedge clk);
    #1;
    check("start_stop_exclusive", 32'(bus.start && bus.stop), 0);
  endtask

  function automatic logic [3:0] cnt_at(input int unsigned mode, input int unsigned seed,
                                        input int unsigned k);
    case (mode)
      0:       return 4'(seed);
      1:       return 4'(seed + k);
      default: return ((k % 2) == 0) ? 4'hF : 4'h0;
    endcase
  endfunction

  task automatic run_vec(input vec_t v);
    vec_t        e;
    int unsigned k_stop = 0;
    int unsigned n_start = 0;
    int unsigned n_stop = 0;
    bit          seen_stop = 1'b0;
    bit          got_done = 1'b0;

    tick();
    bus.req     = 1'b1;
    bus.win_len = WIN_W'(v.win_len);
    bus.abort   = 1'b0;
    bus.stop_d2 = 1'b0;
    bus.count   = cnt_at(v.mode, v.seed, 0);
    sb.push_back(v);

    for (int unsigned k = 1; k <= MAX_CYC && !got_done; k++) begin
      tick();
      if (bus.start) n_start++;
      if (bus.stop)  n_stop++;
      if (bus.stop && !seen_stop) begin
        seen_stop = 1'b1;
        k_stop    = k;
      end
      if (bus.done) begin
        got_done = 1'b1;
        e = sb.pop_front();
        check("done_latency", k, e.exp_lat);
        check("busy_at_done", 32'(bus.busy), 1);
        check("start_cycles", n_start, e.exp_start);
        check("stop_cycles", n_stop, e.exp_stop);
        check("result", 32'(bus.result), e.exp_result);
        check("laps", 32'(bus.laps), e.exp_laps);
        check("err", 32'(bus.err), 32'(e.exp_err));
      end
      bus.count   = cnt_at(v.mode, v.seed, k);
      bus.abort   = (k == v.abort_at);
      bus.stop_d2 = seen_stop && !got_done && (v.ack_dly != NOACK) && (k >= k_stop + v.ack_dly);
      bus.req     = (v.toggle_req && !got_done) ? 1'($urandom_range(0, 1)) : 1'b0;
    end

    if (!got_done) begin
      check("done_timeout", 0, 1);
      void'(sb.pop_front());
      bus.req     = 1'b0;
      bus.stop_d2 = 1'b0;
      bus.abort   = 1'b0;
    end else begin
      // One cycle later: pulse gone, status held in IDLE
      tick();
      check("done_one_cycle", 32'(bus.done), 0);
      check("idle_busy", 32'(bus.busy), 0);
      check("result_hold", 32'(bus.result), v.exp_result);
      check("laps_hold", 32'(bus.laps), v.exp_laps);
      check("err_hold", 32'(bus.err), 32'(v.exp_err));
    end
  endtask

  // Asynchronous reset in the middle of a window: outputs drop at once, no done afterwards
  task automatic reset_mid(input int unsigned len, input int unsigned ncyc, input bit in_stop,
                           input int unsigned exp_laps);
    bit saw = 1'b0;
    tick();
    bus.req     = 1'b1;
    bus.win_len = WIN_W'(len);
    bus.stop_d2 = 1'b0;
    bus.abort   = 1'b0;
    bus.count   = cnt_at(2, 0, 0);
    for (int unsigned k = 1; k <= ncyc; k++) begin
      tick();
      bus.req   = 1'b0;
      bus.count = cnt_at(2, 0, k);
    end
    if (in_stop) check("pre_reset_stop", 32'(bus.stop), 1);
    else         check("pre_reset_start", 32'(bus.start), 1);
    check("pre_reset_laps", 32'(bus.laps), exp_laps);
    #2 reset = 1'b0;
    #1;
    check("rst_start", 32'(bus.start), 0);
    check("rst_stop", 32'(bus.stop), 0);
    check("rst_busy", 32'(bus.busy), 0);
    check("rst_done", 32'(bus.done), 0);
    check("rst_laps", 32'(bus.laps), 0);
    tick();
    tick();
    #3 reset = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (bus.done || bus.busy) saw = 1'b1;
    end
    check("no_done_after_reset", 32'(saw), 0);
  endtask

  initial begin
    vecs[0] = '{20,  0, 3,     1, 0,  0, 20,  4, 25,  8, 1,  0};
    vecs[1] = '{100, 5, 0,     1, 3,  0, 5,   1, 7,   9, 0,  0};
    vecs[2] = '{8,   0, NOACK, 0, 7,  0, 8,   6, 15,  7, 0,  1};
    vecs[3] = '{0,   0, 0,     0, 0,  0, 0,   0, 1,   0, 0,  0};
    vecs[4] = '{200, 0, 2,     2, 0,  1, 200, 3, 204, 0, 15, 0};
    vecs[5] = '{5,   5, 5,     1, 10, 0, 5,   6, 12,  5, 0,  0};
    vecs[6] = '{1,   0, 1,     1, 14, 0, 1,   2, 4,   1, 0,  0};
    vecs[7] = '{3,   2, NOACK, 1, 15, 1, 2,   6, 9,   7, 1,  1};
    vecs[8] = '{2,   0, 0,     0, 4,  0, 2,   1, 4,   4, 0,  0};

    // Reset held low for 10 ns with a zero-length request already pending
    reset       = 1'b0;
    bus.req     = 1'b1;
    bus.win_len = '0;
    bus.abort   = 1'b0;
    bus.count   = '0;
    bus.stop_d2 = 1'b0;
    #2;
    check("reset_start", 32'(bus.start), 0);
    check("reset_stop", 32'(bus.stop), 0);
    check("reset_busy", 32'(bus.busy), 0);
    check("reset_done", 32'(bus.done), 0);
    check("reset_result", 32'(bus.result), 0);
    check("reset_laps", 32'(bus.laps), 0);
    check("reset_err", 32'(bus.err), 0);
    #8 reset = 1'b1;

    // First edge after release must not accept the request
    tick();
    check("first_edge_idle_busy", 32'(bus.busy), 0);
    check("first_edge_idle_done", 32'(bus.done), 0);
    tick();
    check("zero_len_done", 32'(bus.done), 1);
    check("zero_len_start", 32'(bus.start), 0);
    bus.req = 1'b0;
    tick();
    check("zero_len_done_drop", 32'(bus.done), 0);

    // Request held high back into IDLE starts another window
    bus.req = 1'b1;
    tick();
    check("held_req_first_done", 32'(bus.done), 1);
    tick();
    check("held_req_idle_gap", 32'(bus.done), 0);
    tick();
    check("held_req_restart", 32'(bus.done), 1);
    bus.req = 1'b0;
    tick();
    check("held_req_done_drop", 32'(bus.done), 0);

    foreach (vecs[i]) run_vec(vecs[i]);

    reset_mid(50, 6, 1'b0, 3);
    reset_mid(1, 3, 1'b1, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/cnt_window_ctrl.md
CNT_WINDOW_CTRL -- requirements
Module: cnt_window_ctrl

Interface
REQ-001 SHALL have parameter WIN_W, default 8, width of window-length request and elapsed-cycle counter.
REQ-002 SHALL have parameter ACK_TMO, default 6, maximum cycles spent in STOP waiting for stop_d2 before error.
REQ-003 SHALL have port clk  input  1  single clock, all state updates on rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset (0 = reset asserted).
REQ-005 SHALL have port req  input  1  request a counting window; sampled only in IDLE.
REQ-006 SHALL have port win_len  input  WIN_W  window length in clk cycles; sampled with req.
REQ-007 SHALL have port abort  input  1  end the current window early; sampled only in RUN.
REQ-008 SHALL have port count  input  4  current value of the 4-bit start/stop counter.
REQ-009 SHALL have port stop_d2  input  1  counter's two-flop-synchronised stop acknowledge.
REQ-010 SHALL have port start  output  1  counter start level.
REQ-011 SHALL have port stop  output  1  counter stop level.
REQ-012 SHALL have port busy  output  1  high in every state except IDLE.
REQ-013 SHALL have port done  output  1  one-cycle pulse at window completion.
REQ-014 SHALL have port result  output  4  count value captured at window completion.
REQ-015 SHALL have port laps  output  4  count wraps (15->0) seen during RUN, saturating at 15.
REQ-016 SHALL have port err  output  1  sticky stop-acknowledge timeout flag.

Function
REQ-017 SHALL implement FSM states IDLE, RUN, STOP, DONE; all outputs registered.
REQ-018 IDLE: req=1 and win_len!=0 at edge N -> latch win_len, clear laps and err, enter RUN; start=1 from edge N+1.
REQ-019 IDLE: req=1 and win_len==0 -> enter DONE directly, start never asserted, result=0, laps=0.
REQ-020 RUN: start held 1, stop 0; elapsed counter starts at 1 on entry and increments each cycle.
REQ-021 RUN exit to STOP when elapsed==latched win_len or abort=1; abort takes effect on the same edge as a coincident length match (single transition).
REQ-022 RUN: laps increments when count goes 15 to 0 between consecutive samples; holds at 15.
REQ-023 STOP: start=0, stop=1 held; on stop_d2=1 capture count into result and enter DONE.
REQ-024 STOP: if stop_d2 not seen within ACK_TMO cycles, set err, capture count, enter DONE.
REQ-025 DONE: stop=0, start=0, done=1 for exactly one cycle, then IDLE.
REQ-026 start and stop SHALL never be 1 in the same cycle.
REQ-027 req while busy SHALL be ignored (no queuing); req held high into IDLE starts a new window.
REQ-028 result and laps SHALL hold their values until the next accepted req.
REQ-029 err SHALL remain set until the next accepted req or reset.

Reset
REQ-030 reset=0 SHALL immediately force IDLE, start=0, stop=0, busy=0, done=0, result=0, laps=0, err=0, elapsed=0.
REQ-031 reset asserted mid-RUN or mid-STOP SHALL drop start/stop asynchronously with no done pulse.
REQ-032 Deassertion of reset SHALL be followed by at least one cycle in IDLE before req is accepted.

Structure
REQ-033 FSM state encoding and the default ACK_TMO value SHALL live in shared package cnt_ctrl_pkg.
REQ-034 Elapsed/timeout counting SHALL be one sub-module cnt_ctrl_timer (load, enable, terminal-count output), instantiated twice.
REQ-035 Total RTL SHALL remain a single clock domain with no latches.

Verification
REQ-036 reset=0 for 10 ns then 1; req=1, win_len=20, stop_d2 returns 3 cycles after stop -> start high 20 cycles, laps=1, done pulse 1 cycle, result=count at ack, err=0.
REQ-037 req=1, win_len=100, abort=1 on RUN cycle 5 -> start high exactly 5 cycles, stop asserted next cycle, done pulses.
REQ-038 req=1, win_len=8, stop_d2 held 0 -> err=1 after 6 STOP cycles, done pulses, next req clears err.
REQ-039 req=1, win_len=0 -> done pulse 2 cycles after req, start never asserted, result=0.
REQ-040 win_len=200 with count free-running -> laps saturates at 15; reset=0 mid-RUN -> start=0 immediately, no done.
REQ-041 req toggled during RUN and STOP -> ignored; checker asserts start&stop never both 1 throughout.
